// File: rtl/wb_stage.sv
// Writeback stage: decodes completed instructions into register-file writes and retires them in order from a small FIFO.
// Optional build macro WB_FWD_EN adds a combinational forwarding lookup over the buffered entries.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_mem,
    input  logic            wb_stall,
    output logic            write_en,
    output logic [4:0]      write_reg,
    output logic [XLEN-1:0] write_data,
    output logic            retire_valid,
    output logic [31:0]     retire_count
`ifdef WB_FWD_EN
    ,
    input  logic [4:0]      fwd_rs,
    output logic            fwd_hit,
    output logic [XLEN-1:0] fwd_data
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic            fifo_we   [DEPTH];
    logic [4:0]      fifo_rd   [DEPTH];
    logic [XLEN-1:0] fifo_data [DEPTH];

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [4:0]      last_reg;
    logic [XLEN-1:0] last_data;

    logic            enq;
    logic            deq;
    logic [4:0]      dec_op5;
    logic            dec_we;
    logic [XLEN-1:0] dec_data;

    logic unused_instr_bits;
    assign unused_instr_bits = ^{in_instr[31:15], in_instr[1:0]};

    function automatic logic [XLEN-1:0] align_load(input logic [2:0] f3,
                                                   input logic [1:0] a,
                                                   input logic [XLEN-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  align_load = {{(XLEN-8){b[7]}}, b};
            3'b100:  align_load = {{(XLEN-8){1'b0}}, b};
            3'b001:  align_load = {{(XLEN-16){h[15]}}, h};
            3'b101:  align_load = {{(XLEN-16){1'b0}}, h};
            default: align_load = word;
        endcase
    endfunction

    assign dec_op5 = in_instr[6:2];

    always_comb begin
        dec_we   = 1'b0;
        dec_data = in_alu;
        case (dec_op5)
            5'b00000: begin
                dec_we   = 1'b1;
                dec_data = align_load(in_instr[14:12], in_alu[1:0], in_mem);
            end
            5'b11001, 5'b11011: begin
                dec_we   = 1'b1;
                dec_data = in_pc + XLEN'(4);
            end
            5'b00100, 5'b00101, 5'b01100, 5'b01101: dec_we = 1'b1;
            default: dec_we = 1'b0;
        endcase
    end

    // in_ready looks only at the registered count, so a full FIFO costs one bubble
    assign in_ready     = (count < CW'(DEPTH));
    assign enq          = in_valid && in_ready;
    assign deq          = (count != '0) && !wb_stall;
    assign retire_valid = deq;
    assign write_en     = deq && fifo_we[rd_ptr] && (fifo_rd[rd_ptr] != 5'd0);
    assign write_reg    = (count != '0) ? fifo_rd[rd_ptr]   : last_reg;
    assign write_data   = (count != '0) ? fifo_data[rd_ptr] : last_data;

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_we[wr_ptr]   <= dec_we;
            fifo_rd[wr_ptr]   <= in_instr[11:7];
            fifo_data[wr_ptr] <= dec_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            retire_count <= '0;
            last_reg     <= '0;
            last_data    <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) begin
                rd_ptr       <= rd_ptr + 1'b1;
                retire_count <= retire_count + 32'd1;
                last_reg     <= fifo_rd[rd_ptr];
                last_data    <= fifo_data[rd_ptr];
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef WB_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Walk oldest to youngest so the youngest match wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && fifo_we[fwd_idx] &&
                (fifo_rd[fwd_idx] == fwd_rs) && (fwd_rs != 5'd0)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data[fwd_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus random traffic against a queue-based reference model.
module tb_wb_stage;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_alu;
    logic [XLEN-1:0] in_mem;
    logic            wb_stall;
    logic            write_en;
    logic [4:0]      write_reg;
    logic [XLEN-1:0] write_data;
    logic            retire_valid;
    logic [31:0]     retire_count;
`ifdef WB_FWD_EN
    logic [4:0]      fwd_rs;
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_data;
`endif

    wb_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_alu(in_alu), .in_mem(in_mem),
        .wb_stall(wb_stall), .write_en(write_en), .write_reg(write_reg),
        .write_data(write_data), .retire_valid(retire_valid), .retire_count(retire_count)
`ifdef WB_FWD_EN
        , .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] rc    = 0;
    logic [4:0]  last_reg  = 0;
    logic [31:0] last_data = 0;
    logic        acc;

    localparam logic [4:0] OP_LOAD = 5'b00000, OP_IMM = 5'b00100, OP_AUIPC = 5'b00101,
                           OP_OP = 5'b01100, OP_LUI = 5'b01101, OP_JALR = 5'b11001,
                           OP_JAL = 5'b11011, OP_STORE = 5'b01000, OP_BRANCH = 5'b11000,
                           OP_MISC = 5'b00011, OP_SYS = 5'b11100;

    function automatic logic [31:0] mk(logic [4:0] op5, logic [4:0] rd, logic [2:0] f3);
        logic [16:0] hi;
        hi = 17'($urandom);
        return {hi, f3, rd, op5, 2'b11};
    endfunction

    // Reference decode computed from the opcode/funct3 rules with shifts and masks
    function automatic ent_t ref_decode(logic [31:0] ins, logic [31:0] pc,
                                        logic [31:0] alu, logic [31:0] mem);
        ent_t e;
        logic [4:0]  op5;
        logic [2:0]  f3;
        logic [31:0] v;
        int          sh;
        op5  = ins[6:2];
        f3   = ins[14:12];
        e.rd = ins[11:7];
        e.we = (op5 == OP_LOAD) || (op5 == OP_IMM) || (op5 == OP_AUIPC) || (op5 == OP_OP) ||
               (op5 == OP_LUI) || (op5 == OP_JALR) || (op5 == OP_JAL);
        if (op5 == OP_JAL || op5 == OP_JALR) begin
            e.data = pc + 32'd4;
        end else if (op5 == OP_LOAD) begin
            if (f3 == 3'b000 || f3 == 3'b100) begin
                sh = 8 * int'(alu % 4);
                v  = (mem >> sh) & 32'hFF;
                if (f3 == 3'b000 && v >= 32'h80) v = v - 32'd256;
            end else if (f3 == 3'b001 || f3 == 3'b101) begin
                sh = (alu % 4 >= 2) ? 16 : 0;
                v  = (mem >> sh) & 32'hFFFF;
                if (f3 == 3'b001 && v >= 32'h8000) v = v - 32'h10000;
            end else begin
                v = mem;
            end
            e.data = v;
        end else begin
            e.data = alu;
        end
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic ret;
        logic wen;
        ret = (q.size() != 0) && !wb_stall;
        wen = ret && q[0].we && (q[0].rd != 5'd0);
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("retire_valid", 32'(retire_valid), 32'(ret));
        chk("write_en", 32'(write_en), 32'(wen));
        chk("write_reg", 32'(write_reg), 32'((q.size() != 0) ? q[0].rd : last_reg));
        chk("write_data", write_data, (q.size() != 0) ? q[0].data : last_data);
        chk("retire_count", retire_count, rc);
    endtask

    task automatic half1();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic half2();
        logic ready_b;
        @(posedge clk);
        ready_b = (q.size() < DEPTH);
        if (q.size() != 0 && !wb_stall) begin
            last_reg  = q[0].rd;
            last_data = q[0].data;
            void'(q.pop_front());
            rc = rc + 32'd1;
        end
        acc = in_valid && ready_b;
        if (acc) q.push_back(ref_decode(in_instr, in_pc, in_alu, in_mem));
        #1;
    endtask

    task automatic cyc();
        half1();
        half2();
    endtask

    task automatic send(logic [31:0] ins, logic [31:0] pc, logic [31:0] alu, logic [31:0] mem);
        in_instr = ins; in_pc = pc; in_alu = alu; in_mem = mem;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) cyc();
        chk("send_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 10 && q.size() != 0; n++) cyc();
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_alu = '0; in_mem = '0;
        wb_stall = 1'b0;
`ifdef WB_FWD_EN
        fwd_rs = '0;
`endif
        #12;
        check_outputs();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // ADDI x5 = 0x1234: visible the cycle after enqueue, retires at that edge
        send(mk(OP_IMM, 5'd5, 3'b000), 32'h0, 32'h1234, 32'h0);
        half1();
        chk("addi_we", 32'(write_en), 32'd1);
        chk("addi_reg", 32'(write_reg), 32'd5);
        chk("addi_data", write_data, 32'h1234);
        half2();
        chk("addi_rc", retire_count, 32'd1);

        send(mk(OP_LOAD, 5'd3, 3'b000), 32'h40, 32'h1003, 32'h80FF_FF7F);
        half1();
        chk("lb_data", write_data, 32'hFFFF_FF80);
        half2();
        send(mk(OP_LOAD, 5'd4, 3'b101), 32'h44, 32'h1002, 32'h80FF_FF7F);
        half1();
        chk("lhu_data", write_data, 32'h0000_80FF);
        half2();
        send(mk(OP_JAL, 5'd1, 3'b000), 32'h100, 32'h0, 32'h0);
        half1();
        chk("jal_data", write_data, 32'h104);
        half2();
        send(mk(OP_JALR, 5'd2, 3'b000), 32'hFFFF_FFFC, 32'h0, 32'h0);
        cyc();
        send(mk(OP_STORE, 5'd9, 3'b010), 32'h0, 32'h55, 32'h0);
        cyc();
        send(mk(OP_BRANCH, 5'd10, 3'b000), 32'h0, 32'h66, 32'h0);
        cyc();
        send(mk(OP_IMM, 5'd0, 3'b000), 32'h0, 32'h77, 32'h0);
        half1();
        chk("x0_we", 32'(write_en), 32'd0);
        chk("x0_retire", 32'(retire_valid), 32'd1);
        half2();

        // Stall with a full FIFO: third entry must wait, then in-order drain
        wb_stall = 1'b1;
        send(mk(OP_OP, 5'd11, 3'b000), 32'h0, 32'hA1, 32'h0);
        send(mk(OP_LUI, 5'd12, 3'b000), 32'h0, 32'hA2, 32'h0);
        in_instr = mk(OP_AUIPC, 5'd13, 3'b000); in_alu = 32'hA3; in_valid = 1'b1;
        half1();
        chk("full_ready", 32'(in_ready), 32'd0);
        half2();
        wb_stall = 1'b0;
        send(in_instr, 32'h0, 32'hA3, 32'h0);
        drain();

        // Async reset with two entries buffered
        wb_stall = 1'b1;
        send(mk(OP_IMM, 5'd14, 3'b000), 32'h0, 32'hB1, 32'h0);
        send(mk(OP_IMM, 5'd15, 3'b000), 32'h0, 32'hB2, 32'h0);
        #2;
        rst = 1'b0;
        wb_stall = 1'b0;
        q.delete(); rc = 0; last_reg = 0; last_data = 0;
        #1;
        check_outputs();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 400; i++) begin
            logic [4:0] ops[12];
            logic [4:0] op;
            ops = '{OP_LOAD, OP_IMM, OP_AUIPC, OP_OP, OP_LUI, OP_JALR, OP_JAL,
                    OP_STORE, OP_BRANCH, OP_MISC, OP_SYS, OP_LOAD};
            op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : ops[$urandom_range(0, 11)];
            wb_stall = ($urandom_range(0, 3) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = mk(op, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                          3'($urandom));
            in_pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
            in_alu = $urandom;
            in_mem = $urandom;
            cyc();
        end
        in_valid = 1'b0;
        wb_stall = 1'b0;
        drain();

`ifdef WB_FWD_EN
        wb_stall = 1'b1;
        send(mk(OP_IMM, 5'd7, 3'b000), 32'h0, 32'h11, 32'h0);
        send(mk(OP_IMM, 5'd7, 3'b000), 32'h0, 32'h22, 32'h0);
        fwd_rs = 5'd7;
        #1;
        chk("fwd_hit7", 32'(fwd_hit), 32'd1);
        chk("fwd_data7", fwd_data, q[q.size()-1].data);
        fwd_rs = 5'd0;
        #1;
        chk("fwd_hit0", 32'(fwd_hit), 32'd0);
        wb_stall = 1'b0;
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
